// File: rtl/mac_tx_framer.sv
// Ethernet MAC transmit framer: wraps an upstream byte stream with preamble, SFD,
// zero pad, CRC-32 FCS and inter-frame gap, driving a single output register stage.
module mac_tx_framer #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_FRAME      = 60,
  parameter int IFG_BYTES      = 12
) (
  input  logic       phy_tx_clk,
  input  logic       sys_rst,
  input  logic [7:0] mac_tdata_in,
  input  logic       mac_tvalid_in,
  input  logic       mac_tlast_in,
  output logic       mac_tready_out,
  output logic [7:0] phy_txd_out,
  output logic       phy_tvalid_out,
  input  logic       phy_tready_in,
  output logic       phy_terr_out,
  output logic       frame_done_out,
  output logic       underrun_out
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME);
  localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_BYTES - 1);
  localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_IFG      = 3'd6
  } state_t;

  state_t      r_state;
  logic [10:0] r_cnt;
  logic [1:0]  r_fcs_idx;
  logic [31:0] r_crc;
  logic [7:0]  r_txd;
  logic        r_tvalid;
  logic        r_terr;
  logic        r_done;
  logic        r_underrun;

  logic        w_load_en;
  logic [11:0] w_cnt_next;
  logic [31:0] w_crc_data;
  logic [31:0] w_crc_pad;
  logic [31:0] w_fcs;
  logic [7:0]  w_fcs_byte;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int k = 0; k < 8; k++) begin
      fb = c[0] ^ data[k];
      c  = {1'b0, c[31:1]} ^ (fb ? CRC_POLY : 32'h0000_0000);
    end
    return c;
  endfunction

  function automatic logic [10:0] sat_inc(input logic [10:0] c);
    return (c == 11'h7FF) ? c : c + 11'd1;
  endfunction

  assign w_load_en      = !r_tvalid || phy_tready_in;
  assign w_cnt_next     = {1'b0, r_cnt} + 12'd1;
  assign w_crc_data     = crc32_byte(r_crc, mac_tdata_in);
  assign w_crc_pad      = crc32_byte(r_crc, 8'h00);
  assign w_fcs          = ~r_crc;
  assign mac_tready_out = (r_state == ST_DATA) && w_load_en;

  assign phy_txd_out    = r_txd;
  assign phy_tvalid_out = r_tvalid;
  assign phy_terr_out   = r_terr;
  assign frame_done_out = r_done;
  assign underrun_out   = r_underrun;

  // FCS goes out least-significant byte first
  always_comb begin
    w_fcs_byte = 8'h00;
    case (r_fcs_idx)
      2'd0:    w_fcs_byte = w_fcs[7:0];
      2'd1:    w_fcs_byte = w_fcs[15:8];
      2'd2:    w_fcs_byte = w_fcs[23:16];
      2'd3:    w_fcs_byte = w_fcs[31:24];
      default: w_fcs_byte = 8'h00;
    endcase
  end

  // Framer FSM; the output register only moves when load_en is high
  always_ff @(posedge phy_tx_clk) begin
    if (sys_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 11'd0;
      r_fcs_idx  <= 2'd0;
      r_crc      <= CRC_INIT;
      r_txd      <= 8'h00;
      r_tvalid   <= 1'b0;
      r_terr     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_load_en) begin
            if (mac_tvalid_in) begin
              r_txd    <= 8'h55;
              r_tvalid <= 1'b1;
              r_terr   <= 1'b0;
              r_cnt    <= 11'd1;
              r_state  <= (PREAMBLE_BYTES > 1) ? ST_PREAMBLE : ST_SFD;
            end else begin
              r_txd    <= 8'h00;
              r_tvalid <= 1'b0;
              r_terr   <= 1'b0;
            end
          end
        end
        ST_PREAMBLE: begin
          if (w_load_en) begin
            r_txd    <= 8'h55;
            r_tvalid <= 1'b1;
            r_terr   <= 1'b0;
            r_cnt    <= r_cnt + 11'd1;
            if (r_cnt >= PRE_LAST) begin
              r_state <= ST_SFD;
            end
          end
        end
        ST_SFD: begin
          if (w_load_en) begin
            r_txd    <= 8'hD5;
            r_tvalid <= 1'b1;
            r_terr   <= 1'b0;
            r_cnt    <= 11'd0;
            r_crc    <= CRC_INIT;
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_load_en) begin
            r_tvalid <= 1'b1;
            if (mac_tvalid_in) begin
              r_txd  <= mac_tdata_in;
              r_terr <= 1'b0;
              r_crc  <= w_crc_data;
              r_cnt  <= sat_inc(r_cnt);
              if (mac_tlast_in) begin
                r_fcs_idx <= 2'd0;
                r_state   <= (w_cnt_next < MIN_LEN) ? ST_PAD : ST_FCS;
              end
            end else begin
              // Upstream ran dry mid-frame: poison the beat and skip the FCS
              r_txd      <= 8'h00;
              r_terr     <= 1'b1;
              r_underrun <= 1'b1;
              r_state    <= ST_IFG;
            end
          end
        end
        ST_PAD: begin
          if (w_load_en) begin
            r_txd     <= 8'h00;
            r_tvalid  <= 1'b1;
            r_terr    <= 1'b0;
            r_crc     <= w_crc_pad;
            r_cnt     <= sat_inc(r_cnt);
            r_fcs_idx <= 2'd0;
            if (w_cnt_next >= MIN_LEN) begin
              r_state <= ST_FCS;
            end
          end
        end
        ST_FCS: begin
          if (w_load_en) begin
            r_txd     <= w_fcs_byte;
            r_tvalid  <= 1'b1;
            r_terr    <= 1'b0;
            r_fcs_idx <= r_fcs_idx + 2'd1;
            if (r_fcs_idx == 2'd3) begin
              r_state <= ST_IFG;
            end
          end
        end
        ST_IFG: begin
          if (r_tvalid) begin
            if (phy_tready_in) begin
              r_txd    <= 8'h00;
              r_tvalid <= 1'b0;
              r_terr   <= 1'b0;
              r_done   <= !r_terr;
              r_cnt    <= 11'd1;
              if (IFG_BYTES <= 1) begin
                r_state <= ST_IDLE;
              end
            end
          end else if (r_cnt >= IFG_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 11'd1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_tvalid <= 1'b0;
          r_terr   <= 1'b0;
        end
      endcase
    end
  end

endmodule
